// File: rtl/q_write_arbiter.sv
// q_write_arbiter: round-robin arbiter that lets NREQ requesters share one
// WIDTH-bit register q. A request sampled in IDLE is granted for one cycle,
// its data is captured at the end of the grant cycle, committed to q one cycle
// later, and followed by HOLD idle cycles before the next request is sampled.
// Optional build macro: Q_ARB_FIXED_PRIORITY_EN selects lowest-index-wins
// priority and removes the round-robin pointer.
module q_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int HOLD  = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NREQ-1:0]                       req,
  input  logic [NREQ*WIDTH-1:0]                 wdata,
  output logic [NREQ-1:0]                       grant,
  output logic [WIDTH-1:0]                      q,
  output logic                                  q_valid,
  output logic [((NREQ > 2) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic                                  busy
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WRITE,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              busy_q, busy_d;
`ifndef Q_ARB_FIXED_PRIORITY_EN
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
`endif

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  int                cand;

  // Winner search: first set req bit scanning upward from the start index.
  // NOTE: every variable written in an always_comb gets a default at the top,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef Q_ARB_FIXED_PRIORITY_EN
      cand = i;
`else
      cand = int'(rr_ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
`endif
      if (!pick_found && req[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/GRANT/WRITE/HOLD FSM.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    grant_d     = '0;
    q_d         = q_q;
    q_valid_d   = 1'b0;
    owner_d     = owner_q;
`ifndef Q_ARB_FIXED_PRIORITY_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          win_d             = pick_idx;
          grant_d[pick_idx] = 1'b1;
          state_d           = S_GRANT;
        end
      end
      S_GRANT: begin
        // Data is taken at the end of the grant cycle, so the requester may
        // drop req in this cycle without losing the write.
        hold_data_d = wdata[int'(win_q)*WIDTH +: WIDTH];
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        q_d       = hold_data_q;
        q_valid_d = 1'b1;
        owner_d   = win_q;
`ifndef Q_ARB_FIXED_PRIORITY_EN
        rr_ptr_d  = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
        if (HOLD > 0) begin
          hold_cnt_d = 4'(HOLD - 1);
          state_d    = S_HOLD;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == 4'd0) state_d = S_IDLE;
        else                    hold_cnt_d = hold_cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      grant_q     <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
`ifndef Q_ARB_FIXED_PRIORITY_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      hold_data_q <= hold_data_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_q     <= grant_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
`ifndef Q_ARB_FIXED_PRIORITY_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_q_write_arbiter.sv
// Self-checking bench for q_write_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a transaction-level
// model that tracks each request by its age in cycles since it was accepted.
module tb_q_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int HOLD  = 1;
  localparam int IW    = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   wdata;
  logic [NREQ-1:0]         grant;
  logic [WIDTH-1:0]        q;
  logic                    q_valid;
  logic [IW-1:0]           owner;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int               edge_n    = 0;
  int               txn_start = -1;
  int               m_win     = 0;
  int               m_ptr     = 0;
  int               m_owner   = 0;
  logic [WIDTH-1:0] m_cap     = '0;
  logic [WIDTH-1:0] m_q       = '0;
  logic [NREQ-1:0]  m_grant   = '0;
  logic             m_qv      = 1'b0;
  logic             m_busy    = 1'b0;

  logic [WIDTH-1:0] qlog[$];

  q_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .grant   (grant),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int from);
`ifdef Q_ARB_FIXED_PRIORITY_EN
    from = 0;
`endif
    for (int i = 0; i < NREQ; i++)
      if (r[(from + i) % NREQ]) return (from + i) % NREQ;
    return -1;
  endfunction

  // One clock edge of the model: a request lives 3+HOLD edges from the edge
  // it is accepted; grant follows acceptance, capture is at age 1, commit at
  // age 2, and busy covers ages 0..1+HOLD.
  task automatic model_edge();
    int age;
    int w;
    m_grant = '0;
    m_qv    = 1'b0;
    if (reset) begin
      txn_start = -1;
      m_ptr     = 0;
      m_q       = '0;
      m_owner   = 0;
    end else begin
      age = (txn_start < 0) ? 1000 : edge_n - txn_start;
      if (age >= 3 + HOLD) begin
        w = pick(req, m_ptr);
        if (w >= 0) begin
          txn_start  = edge_n;
          m_win      = w;
          m_grant[w] = 1'b1;
        end
      end else if (age == 1) begin
        m_cap = wdata[m_win*WIDTH +: WIDTH];
      end else if (age == 2) begin
        m_q     = m_cap;
        m_qv    = 1'b1;
        m_owner = m_win;
        m_ptr   = (m_win + 1) % NREQ;
      end
    end
    m_busy = (txn_start >= 0) && (edge_n - txn_start < 2 + HOLD);
    edge_n++;
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] wd);
    reset = r;
    req   = rq;
    wdata = wd;
    @(posedge clock);
    model_edge();
    #1;
    check("grant",   32'(grant),   32'(m_grant));
    check("q",       32'(q),       32'(m_q));
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("owner",   32'(owner),   32'(m_owner));
    check("busy",    32'(busy),    32'(m_busy));
    if (q_valid === 1'b1) qlog.push_back(q);
  endtask

  initial begin
    logic [NREQ-1:0]       rq;
    logic [NREQ*WIDTH-1:0] wd;
    reset = 1'b1;
    req   = '0;
    wdata = '0;

    // Reset values with every requester asking
    step(1'b1, 4'b1111, 16'hFFFF);
    step(1'b1, 4'b1111, 16'hFFFF);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_q",     32'(q),     32'd0);
    check("reset_busy",  32'(busy),  32'd0);

    // Single write from requester 2
    step(1'b0, 4'b0100, 16'h0F00);
    check("single_grant", 32'(grant), 32'b0100);
    step(1'b0, 4'b0000, 16'h0F00);
    step(1'b0, 4'b0000, 16'h0F00);
    check("single_q",     32'(q),       32'hF);
    check("single_qv",    32'(q_valid), 32'd1);
    check("single_owner", 32'(owner),   32'd2);
    step(1'b0, 4'b0000, 16'h0F00);
    step(1'b0, 4'b0000, 16'h0F00);
    check("single_busy_low", 32'(busy), 32'd0);

    // Round-robin fairness from a fresh pointer
    step(1'b1, 4'b0000, 16'h0000);
    qlog.delete();
    for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, 16'h3210);
    check("rr_count", 32'(qlog.size()), 32'd5);
    if (qlog.size() == 5) begin
`ifdef Q_ARB_FIXED_PRIORITY_EN
      for (int i = 0; i < 5; i++) check("rr_seq", 32'(qlog[i]), 32'd0);
`else
      for (int i = 0; i < 5; i++) check("rr_seq", 32'(qlog[i]), 32'(i % 4));
`endif
    end

    // Wrap-around: write from 2 leaves the pointer at 3, then req=0011
    step(1'b1, 4'b0000, 16'hDCBA);
    step(1'b0, 4'b0100, 16'hDCBA);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 16'hDCBA);
    qlog.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0011, 16'hDCBA);
    check("wrap_count", 32'(qlog.size()), 32'd2);
    if (qlog.size() == 2) begin
      check("wrap_first", 32'(qlog[0]), 32'hA);
`ifdef Q_ARB_FIXED_PRIORITY_EN
      check("wrap_second", 32'(qlog[1]), 32'hA);
`else
      check("wrap_second", 32'(qlog[1]), 32'hB);
`endif
    end

    // Data changes and req drops during the grant cycle
    step(1'b1, 4'b0000, 16'h0010);
    step(1'b0, 4'b0010, 16'h0010);
    step(1'b0, 4'b0000, 16'h00F0);
    step(1'b0, 4'b0000, 16'h00F0);
    check("capture_q", 32'(q), 32'hF);
    step(1'b0, 4'b0000, 16'h00F0);

    // Reset pulsed during WRITE discards the pending capture
    step(1'b1, 4'b0000, 16'h0050);
    step(1'b0, 4'b0010, 16'h0050);
    step(1'b0, 4'b0000, 16'h0050);
    step(1'b1, 4'b0000, 16'h0050);
    check("midrst_q",  32'(q),       32'd0);
    check("midrst_qv", 32'(q_valid), 32'd0);
    step(1'b0, 4'b0000, 16'h7008);
    step(1'b0, 4'b1001, 16'h7008);
    check("midrst_grant", 32'(grant), 32'b0001);
    step(1'b0, 4'b0000, 16'h7008);
    step(1'b0, 4'b0000, 16'h7008);
    check("midrst_q_after",     32'(q),     32'h8);
    check("midrst_owner_after", 32'(owner), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      wd = 16'($urandom);
      step(($urandom_range(0, 59) == 0), rq, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
